// File: rtl/camera_pixel_assembler.sv
// -----------------------------------------------------------------------------
// camera_pixel_assembler
//
// DVP camera front end. The camera pins (PCLK, HS, VS, data) are treated as
// plain asynchronous data: they pass together through a short synchroniser
// chain in the clk_in domain, PCLK rising edges are detected from the
// synchronised copy, and each detected edge ("sample") captures one byte.
// BYTES_PER_PIXEL bytes are packed into one pixel, which is emitted with its
// column/row position and frame/line framing strobes.
//
// Parameters
//   HCOUNT_WIDTH     width of pixel_hcount_out
//   VCOUNT_WIDTH     width of pixel_vcount_out
//   DATA_WIDTH       camera bus width (bits per byte)
//   BYTES_PER_PIXEL  bytes packed per pixel, 1..4
//   MSB_FIRST        1: first byte lands in the pixel MSBs, 0: in the LSBs
//   SYNC_STAGES      synchroniser flops ahead of edge detection, 0..3
//   H_ACTIVE         expected pixels per line, 0 disables the length check
//
// Ports
//   clk_in                 system clock, at least 3x the camera PCLK
//   rst_in                 asynchronous active-high reset
//   camera_pclk_in         camera pixel clock, sampled as data
//   camera_hs_in           line valid
//   camera_vs_in           frame valid
//   camera_data_in         camera byte
//   pixel_valid_out        one-cycle strobe, pixel_* fields valid
//   pixel_hcount_out       column of the emitted pixel
//   pixel_vcount_out       row of the emitted pixel
//   pixel_data_out         packed pixel
//   frame_start_out        with the valid of pixel (0,0)
//   line_end_out           strobe on the sampled end of a line
//   frame_done_out         strobe on the sampled end of a frame
//   line_len_err_out       with line_end when the pixel count != H_ACTIVE
//   partial_pixel_err_out  with line_end when a pixel was left incomplete
// -----------------------------------------------------------------------------
module camera_pixel_assembler #(
    parameter int HCOUNT_WIDTH    = 11,
    parameter int VCOUNT_WIDTH    = 10,
    parameter int DATA_WIDTH      = 8,
    parameter int BYTES_PER_PIXEL = 1,
    parameter int MSB_FIRST       = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int H_ACTIVE        = 0
) (
    input  logic                                    clk_in,
    input  logic                                    rst_in,
    input  logic                                    camera_pclk_in,
    input  logic                                    camera_hs_in,
    input  logic                                    camera_vs_in,
    input  logic [DATA_WIDTH-1:0]                   camera_data_in,
    output logic                                    pixel_valid_out,
    output logic [HCOUNT_WIDTH-1:0]                 pixel_hcount_out,
    output logic [VCOUNT_WIDTH-1:0]                 pixel_vcount_out,
    output logic [BYTES_PER_PIXEL*DATA_WIDTH-1:0]   pixel_data_out,
    output logic                                    frame_start_out,
    output logic                                    line_end_out,
    output logic                                    frame_done_out,
    output logic                                    line_len_err_out,
    output logic                                    partial_pixel_err_out
);

    localparam int PIX_W  = BYTES_PER_PIXEL * DATA_WIDTH;
    localparam int SYNC_W = DATA_WIDTH + 3;
    // One bit wider than hcount so an over-long line still reads as != H_ACTIVE
    // even when hcount itself has wrapped.
    localparam int CNT_W  = HCOUNT_WIDTH + 1;

    localparam logic [1:0]        LAST_IDX  = 2'(BYTES_PER_PIXEL - 1);
    localparam logic [CNT_W-1:0]  H_EXPECT  = CNT_W'(H_ACTIVE);
    localparam bit                LEN_CHECK = (H_ACTIVE != 0);
    // PCLK copies come out of reset high so the first real low->high
    // transition is the first edge seen; HS/VS/data come out low.
    localparam logic [SYNC_W-1:0] SYNC_RST  = {1'b1, 2'b00, {DATA_WIDTH{1'b0}}};

    // -------------------------------------------------------------------------
    // Reset: asserted asynchronously, released on a clock edge so every flop
    // below leaves reset in the same cycle.
    // -------------------------------------------------------------------------
    logic [1:0] rst_pipe_reg;
    logic       core_rst;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rst_pipe_reg <= 2'b11;
        end else begin
            rst_pipe_reg <= {rst_pipe_reg[0], 1'b0};
        end
    end

    assign core_rst = rst_pipe_reg[1];

    // -------------------------------------------------------------------------
    // Input synchroniser. All four camera signals share one chain so the
    // sampled byte and the framing bits stay aligned with the PCLK edge.
    // -------------------------------------------------------------------------
    logic [SYNC_W-1:0] raw_bus;
    logic [SYNC_W-1:0] sync_bus;

    assign raw_bus = {camera_pclk_in, camera_hs_in, camera_vs_in, camera_data_in};

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sync_bus = raw_bus;
        end else begin : g_sync
            logic [SYNC_W-1:0] sync_reg [SYNC_STAGES];

            for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
                logic [SYNC_W-1:0] stage_src;

                if (gi == 0) begin : g_head
                    assign stage_src = raw_bus;
                end else begin : g_tail
                    assign stage_src = sync_reg[gi-1];
                end

                always_ff @(posedge clk_in or posedge core_rst) begin
                    if (core_rst) begin
                        sync_reg[gi] <= SYNC_RST;
                    end else begin
                        sync_reg[gi] <= stage_src;
                    end
                end
            end

            assign sync_bus = sync_reg[SYNC_STAGES-1];
        end
    endgenerate

    logic                  pclk_s;
    logic                  hs_s;
    logic                  vs_s;
    logic [DATA_WIDTH-1:0] data_s;

    assign {pclk_s, hs_s, vs_s, data_s} = sync_bus;

    // -------------------------------------------------------------------------
    // Sample / framing decode
    // -------------------------------------------------------------------------
    logic             pclk_prev_reg;
    logic             hs_prev_reg;
    logic             vs_prev_reg;
    logic [1:0]       byte_idx_reg;
    logic [CNT_W-1:0] pix_cnt_reg;

    logic sample;
    logic active;
    logic last_byte;
    logic hs_fall;
    logic vs_fall;
    logic line_end_hit;

    assign sample    = ~pclk_prev_reg & pclk_s;
    assign active    = hs_s & vs_s;
    assign last_byte = (byte_idx_reg == LAST_IDX);
    assign hs_fall   = hs_prev_reg & ~hs_s;
    assign vs_fall   = vs_prev_reg & ~vs_s;
    // A line also ends when VS drops while HS was still high; the line is
    // closed out in the same sample that reports the frame end.
    assign line_end_hit = (hs_fall & vs_s) | (vs_fall & hs_prev_reg);

    // -------------------------------------------------------------------------
    // Byte packing. pixel_word is the pixel as it would stand once the byte
    // of the current sample is included; it is registered out on the last
    // byte of a pixel.
    // -------------------------------------------------------------------------
    logic [PIX_W-1:0] pixel_word;

    generate
        if (BYTES_PER_PIXEL == 1) begin : g_single_byte
            assign pixel_word = data_s;
        end else begin : g_multi_byte
            logic [PIX_W-1:0] acc_reg;

            if (MSB_FIRST != 0) begin : g_msb_first
                // Shift left: earlier bytes migrate toward the MSBs.
                assign pixel_word = {acc_reg[PIX_W-DATA_WIDTH-1:0], data_s};
            end else begin : g_lsb_first
                // Shift right: earlier bytes migrate toward the LSBs.
                assign pixel_word = {data_s, acc_reg[PIX_W-1:DATA_WIDTH]};
            end

            always_ff @(posedge clk_in or posedge core_rst) begin
                if (core_rst) begin
                    acc_reg <= '0;
                end else if (sample) begin
                    if (active && !last_byte) begin
                        acc_reg <= pixel_word;
                    end else begin
                        // Completed pixel or broken line: start clean.
                        acc_reg <= '0;
                    end
                end
            end
        end
    endgenerate

    // Column of a pixel completed on this sample.
    logic [HCOUNT_WIDTH-1:0] hcount_next;

    always_comb begin
        hcount_next = '0;
        if (pix_cnt_reg != '0) begin
            hcount_next = pixel_hcount_out + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Main state and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge core_rst) begin
        if (core_rst) begin
            pclk_prev_reg         <= 1'b1;
            hs_prev_reg           <= 1'b0;
            vs_prev_reg           <= 1'b0;
            byte_idx_reg          <= 2'd0;
            pix_cnt_reg           <= '0;
            pixel_valid_out       <= 1'b0;
            pixel_hcount_out      <= '0;
            pixel_vcount_out      <= '0;
            pixel_data_out        <= '0;
            frame_start_out       <= 1'b0;
            line_end_out          <= 1'b0;
            frame_done_out        <= 1'b0;
            line_len_err_out      <= 1'b0;
            partial_pixel_err_out <= 1'b0;
        end else begin
            pclk_prev_reg <= pclk_s;

            // Strobes default low; only a sample cycle may raise them.
            pixel_valid_out       <= 1'b0;
            frame_start_out       <= 1'b0;
            line_end_out          <= 1'b0;
            frame_done_out        <= 1'b0;
            line_len_err_out      <= 1'b0;
            partial_pixel_err_out <= 1'b0;

            if (sample) begin
                // Framing history advances on samples only, so an HS pulse
                // that never coincides with a PCLK edge is invisible.
                hs_prev_reg <= hs_s;
                vs_prev_reg <= vs_s;

                if (active) begin
                    if (last_byte) begin
                        byte_idx_reg     <= 2'd0;
                        pixel_valid_out  <= 1'b1;
                        pixel_data_out   <= pixel_word;
                        pixel_hcount_out <= hcount_next;
                        frame_start_out  <= (hcount_next == '0) && (pixel_vcount_out == '0);
                        // Saturate so a runaway line never reads back as empty.
                        if (pix_cnt_reg != '1) begin
                            pix_cnt_reg <= pix_cnt_reg + 1'b1;
                        end
                    end else begin
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                    end
                end else begin
                    byte_idx_reg <= 2'd0;
                end

                if (line_end_hit) begin
                    line_end_out          <= 1'b1;
                    line_len_err_out      <= LEN_CHECK && (pix_cnt_reg != H_EXPECT);
                    partial_pixel_err_out <= (byte_idx_reg != 2'd0);
                    pix_cnt_reg           <= '0;
                    // Empty lines do not consume a row number.
                    if (vs_s && (pix_cnt_reg != '0)) begin
                        pixel_vcount_out <= pixel_vcount_out + 1'b1;
                    end
                end

                if (!vs_s) begin
                    pixel_vcount_out <= '0;
                    pix_cnt_reg      <= '0;
                end

                frame_done_out <= vs_fall;
            end
        end
    end

endmodule

// File: tb/tb_camera_pixel_assembler.sv
// -----------------------------------------------------------------------------
// Bench for camera_pixel_assembler. Three instances with different packing
// options share one camera bus. A reference model derives the expected
// pixel/line/frame events from the byte stream as it is driven and queues
// them per instance; independent monitors pop and compare whenever an
// instance raises any output strobe.
// -----------------------------------------------------------------------------
module tb_camera_pixel_assembler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       cam_pclk;
    logic       cam_hs;
    logic       cam_vs;
    logic [7:0] cam_data;

    // Instance 0: Y8, H_ACTIVE=8
    logic        u0_v, u0_fs, u0_le, u0_fd, u0_lle, u0_ppe;
    logic [10:0] u0_hc;
    logic [9:0]  u0_vc;
    logic [7:0]  u0_d;
    // Instance 1: 16-bit, first byte in MSBs, no length check
    logic        u1_v, u1_fs, u1_le, u1_fd, u1_lle, u1_ppe;
    logic [10:0] u1_hc;
    logic [9:0]  u1_vc;
    logic [15:0] u1_d;
    // Instance 2: 16-bit, first byte in LSBs, H_ACTIVE=4
    logic        u2_v, u2_fs, u2_le, u2_fd, u2_lle, u2_ppe;
    logic [10:0] u2_hc;
    logic [9:0]  u2_vc;
    logic [15:0] u2_d;

    camera_pixel_assembler #(.BYTES_PER_PIXEL(1), .MSB_FIRST(1), .H_ACTIVE(8)) u_dut0 (
        .clk_in(clk), .rst_in(rst), .camera_pclk_in(cam_pclk), .camera_hs_in(cam_hs),
        .camera_vs_in(cam_vs), .camera_data_in(cam_data), .pixel_valid_out(u0_v),
        .pixel_hcount_out(u0_hc), .pixel_vcount_out(u0_vc), .pixel_data_out(u0_d),
        .frame_start_out(u0_fs), .line_end_out(u0_le), .frame_done_out(u0_fd),
        .line_len_err_out(u0_lle), .partial_pixel_err_out(u0_ppe));

    camera_pixel_assembler #(.BYTES_PER_PIXEL(2), .MSB_FIRST(1), .H_ACTIVE(0)) u_dut1 (
        .clk_in(clk), .rst_in(rst), .camera_pclk_in(cam_pclk), .camera_hs_in(cam_hs),
        .camera_vs_in(cam_vs), .camera_data_in(cam_data), .pixel_valid_out(u1_v),
        .pixel_hcount_out(u1_hc), .pixel_vcount_out(u1_vc), .pixel_data_out(u1_d),
        .frame_start_out(u1_fs), .line_end_out(u1_le), .frame_done_out(u1_fd),
        .line_len_err_out(u1_lle), .partial_pixel_err_out(u1_ppe));

    camera_pixel_assembler #(.BYTES_PER_PIXEL(2), .MSB_FIRST(0), .H_ACTIVE(4)) u_dut2 (
        .clk_in(clk), .rst_in(rst), .camera_pclk_in(cam_pclk), .camera_hs_in(cam_hs),
        .camera_vs_in(cam_vs), .camera_data_in(cam_data), .pixel_valid_out(u2_v),
        .pixel_hcount_out(u2_hc), .pixel_vcount_out(u2_vc), .pixel_data_out(u2_d),
        .frame_start_out(u2_fs), .line_end_out(u2_le), .frame_done_out(u2_fd),
        .line_len_err_out(u2_lle), .partial_pixel_err_out(u2_ppe));

    typedef struct packed {
        logic        pix;
        logic [10:0] hc;
        logic [9:0]  vc;
        logic [31:0] data;
        logic        fs;
        logic        le;
        logic        lle;
        logic        ppe;
        logic        fd;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];
    ev_t q2[$];

    int checks = 0;
    int errors = 0;

    // Reference model state per instance
    int          bpp  [3] = '{1, 2, 2};
    int          msb  [3] = '{1, 1, 0};
    int          hact [3] = '{8, 0, 4};
    int          m_cnt[3];
    int          m_pix[3];
    int          m_row[3];
    logic [31:0] m_acc[3];

    logic [7:0] line_buf[$];

    task automatic push_ev(input int d, input ev_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_cnt[d] = 0; m_pix[d] = 0; m_row[d] = 0; m_acc[d] = '0;
        end
    endtask

    // One byte captured while the line and frame are both valid.
    task automatic model_byte(input logic [7:0] b);
        ev_t e;
        for (int d = 0; d < 3; d++) begin
            if (msb[d] != 0) m_acc[d] = (m_acc[d] << 8) | {24'd0, b};
            else             m_acc[d] = m_acc[d] | ({24'd0, b} << (8 * m_cnt[d]));
            m_cnt[d]++;
            if (m_cnt[d] == bpp[d]) begin
                e = '0;
                e.pix  = 1'b1;
                e.hc   = 11'(m_pix[d]);
                e.vc   = 10'(m_row[d]);
                e.data = m_acc[d];
                e.fs   = (m_pix[d] == 0) && (m_row[d] == 0);
                push_ev(d, e);
                m_pix[d]++;
                m_cnt[d] = 0;
                m_acc[d] = '0;
            end
        end
    endtask

    task automatic model_line_end(input bit with_fd);
        ev_t e;
        for (int d = 0; d < 3; d++) begin
            e = '0;
            e.le  = 1'b1;
            e.lle = (hact[d] != 0) && (m_pix[d] != hact[d]);
            e.ppe = (m_cnt[d] != 0);
            e.fd  = with_fd;
            push_ev(d, e);
            if (with_fd)            m_row[d] = 0;
            else if (m_pix[d] != 0) m_row[d] = (m_row[d] + 1) % 1024;
            m_pix[d] = 0; m_cnt[d] = 0; m_acc[d] = '0;
        end
    endtask

    task automatic model_frame_done();
        ev_t e;
        for (int d = 0; d < 3; d++) begin
            e = '0;
            e.fd = 1'b1;
            push_ev(d, e);
            m_row[d] = 0; m_pix[d] = 0; m_cnt[d] = 0; m_acc[d] = '0;
        end
    endtask

    task automatic check_ev(input int d, input ev_t o);
        ev_t e;
        bit  have;
        bit  ok;
        have = 1'b0;
        e    = '0;
        case (d)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL dut%0d unexpected_event got pix=%0b le=%0b fd=%0b hc=%0d vc=%0d data=%h, required no event",
                     d, o.pix, o.le, o.fd, o.hc, o.vc, o.data);
            return;
        end
        if (e.pix) ok = (o == e);
        else       ok = ({o.pix, o.fs, o.le, o.lle, o.ppe, o.fd} == {e.pix, e.fs, e.le, e.lle, e.ppe, e.fd});
        if (!ok) begin
            errors++;
            $display("FAIL dut%0d event got pix=%0b hc=%0d vc=%0d data=%h fs=%0b le=%0b lle=%0b ppe=%0b fd=%0b required pix=%0b hc=%0d vc=%0d data=%h fs=%0b le=%0b lle=%0b ppe=%0b fd=%0b",
                     d, o.pix, o.hc, o.vc, o.data, o.fs, o.le, o.lle, o.ppe, o.fd,
                     e.pix, e.hc, e.vc, e.data, e.fs, e.le, e.lle, e.ppe, e.fd);
        end else if (e.pix) begin
            $display("dut%0d pixel hc=%0d vc=%0d data=%h fs=%0b ok", d, o.hc, o.vc, o.data, o.fs);
        end else begin
            $display("dut%0d framing le=%0b lle=%0b ppe=%0b fd=%0b ok", d, o.le, o.lle, o.ppe, o.fd);
        end
    endtask

    // Monitors: any raised strobe is one observed event.
    always @(negedge clk) begin
        ev_t o;
        if (u0_v | u0_fs | u0_le | u0_fd | u0_lle | u0_ppe) begin
            o = '{pix: u0_v, hc: u0_hc, vc: u0_vc, data: {24'd0, u0_d}, fs: u0_fs,
                  le: u0_le, lle: u0_lle, ppe: u0_ppe, fd: u0_fd};
            check_ev(0, o);
        end
    end

    always @(negedge clk) begin
        ev_t o;
        if (u1_v | u1_fs | u1_le | u1_fd | u1_lle | u1_ppe) begin
            o = '{pix: u1_v, hc: u1_hc, vc: u1_vc, data: {16'd0, u1_d}, fs: u1_fs,
                  le: u1_le, lle: u1_lle, ppe: u1_ppe, fd: u1_fd};
            check_ev(1, o);
        end
    end

    always @(negedge clk) begin
        ev_t o;
        if (u2_v | u2_fs | u2_le | u2_fd | u2_lle | u2_ppe) begin
            o = '{pix: u2_v, hc: u2_hc, vc: u2_vc, data: {16'd0, u2_d}, fs: u2_fs,
                  le: u2_le, lle: u2_lle, ppe: u2_ppe, fd: u2_fd};
            check_ev(2, o);
        end
    end

    // ------------------------------------------------------------------ drivers
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One camera PCLK period; the rising edge in the middle is the sample.
    task automatic pclk_cycle(input logic hs, input logic vs, input logic [7:0] d);
        cam_pclk = 1'b0; cam_hs = hs; cam_vs = vs; cam_data = d;
        wait_clks(4);
        cam_pclk = 1'b1;
        wait_clks(4);
    endtask

    function automatic logic [7:0] rbyte();
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic fill_seq(input int n, input logic [7:0] start);
        logic [7:0] b;
        line_buf.delete();
        b = start;
        for (int i = 0; i < n; i++) begin
            line_buf.push_back(b);
            b = b + 8'd1;
        end
    endtask

    task automatic fill_rand(input int n);
        line_buf.delete();
        for (int i = 0; i < n; i++) line_buf.push_back(rbyte());
    endtask

    task automatic frame_begin();
        pclk_cycle(1'b0, 1'b1, rbyte());
        pclk_cycle(1'b0, 1'b1, rbyte());
    endtask

    // Drive line_buf. With close_frame, VS drops while HS is still high.
    task automatic drive_line(input bit close_frame);
        foreach (line_buf[i]) begin
            model_byte(line_buf[i]);
            pclk_cycle(1'b1, 1'b1, line_buf[i]);
        end
        if (!close_frame) begin
            model_line_end(1'b0);
            pclk_cycle(1'b0, 1'b1, rbyte());
        end else begin
            model_line_end(1'b1);
            pclk_cycle(1'b1, 1'b0, rbyte());
            pclk_cycle(1'b0, 1'b0, rbyte());
        end
    endtask

    // HS pulse that never overlaps a PCLK rising edge.
    task automatic blank_hs();
        cam_hs = 1'b1;
        wait_clks(3);
        cam_hs = 1'b0;
        wait_clks(3);
    endtask

    task automatic check_vcount_zero();
        wait_clks(12);
        checks++;
        if ({u0_vc, u1_vc, u2_vc} != 30'd0) begin
            errors++;
            $display("FAIL vcount_after_frame got %0d/%0d/%0d required 0/0/0", u0_vc, u1_vc, u2_vc);
        end
    endtask

    task automatic frame_end();
        model_frame_done();
        pclk_cycle(1'b0, 1'b0, rbyte());
        pclk_cycle(1'b0, 1'b0, rbyte());
        check_vcount_zero();
    endtask

    task automatic check_all_zero(input string tag);
        logic [34:0] a0, a1, a2;
        a0 = {u0_v, u0_hc, u0_vc, u0_d, u0_fs, u0_le, u0_fd, u0_lle, u0_ppe};
        a1 = {u1_v, u1_hc, u1_vc, u1_d, u1_fs, u1_le, u1_fd, u1_lle, u1_ppe, 8'd0} >> 8;
        a2 = {u2_v, u2_hc, u2_vc, u2_d, u2_fs, u2_le, u2_fd, u2_lle, u2_ppe, 8'd0} >> 8;
        checks++;
        if (a0 != '0 || {u1_v, u1_hc, u1_vc, u1_d, u1_fs, u1_le, u1_fd, u1_lle, u1_ppe} != '0
                     || {u2_v, u2_hc, u2_vc, u2_d, u2_fs, u2_le, u2_fd, u2_lle, u2_ppe} != '0) begin
            errors++;
            $display("FAIL %s outputs got %h/%h/%h required all 0", tag, a0, a1, a2);
        end else begin
            $display("%s all outputs 0 ok", tag);
        end
    endtask

    task automatic check_queues_empty(input string tag);
        checks++;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            errors++;
            $display("FAIL %s pending got %0d/%0d/%0d events required 0/0/0",
                     tag, q0.size(), q1.size(), q2.size());
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int  nl;
        bit  close;
        rst = 1'b1; cam_pclk = 1'b0; cam_hs = 1'b0; cam_vs = 1'b0; cam_data = 8'd0;
        model_reset();
        wait_clks(4);
        check_all_zero("reset_state");
        rst = 1'b0;
        wait_clks(6);

        // Four lines of 0x00..0x07
        frame_begin();
        for (int l = 0; l < 4; l++) begin
            fill_seq(8, 8'h00);
            drive_line(1'b0);
        end
        frame_end();

        // Packing order, partial pixel, line lengths 8/7/9, blank line,
        // frame closed while HS is still high
        frame_begin();
        line_buf.delete();
        line_buf = '{8'hAB, 8'hCD, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        drive_line(1'b0);
        fill_seq(7, 8'h20);
        drive_line(1'b0);
        fill_seq(9, 8'h30);
        drive_line(1'b0);
        blank_hs();
        pclk_cycle(1'b0, 1'b1, rbyte());
        fill_seq(8, 8'h40);
        drive_line(1'b0);
        fill_seq(5, 8'h60);
        drive_line(1'b1);
        check_vcount_zero();

        // Randomised frames
        for (int f = 0; f < 6; f++) begin
            frame_begin();
            nl    = $urandom_range(1, 4);
            close = 1'b0;
            for (int l = 0; l < nl; l++) begin
                fill_rand($urandom_range(1, 11));
                close = (l == nl - 1) && ($urandom_range(0, 2) == 0);
                drive_line(close);
                if (!close) begin
                    if ($urandom_range(0, 2) == 0) blank_hs();
                    if ($urandom_range(0, 1) == 0) pclk_cycle(1'b0, 1'b1, rbyte());
                end
            end
            if (!close) frame_end();
            else        check_vcount_zero();
        end

        // Reset in the middle of a pixel
        frame_begin();
        fill_seq(3, 8'h70);
        foreach (line_buf[i]) begin
            model_byte(line_buf[i]);
            pclk_cycle(1'b1, 1'b1, line_buf[i]);
        end
        wait_clks(12);
        check_queues_empty("before_reset");
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        cam_pclk = 1'b0; cam_hs = 1'b0; cam_vs = 1'b0;
        model_reset();
        wait_clks(3);
        rst = 1'b0;
        wait_clks(8);
        check_all_zero("reset_release");

        frame_begin();
        fill_seq(8, 8'h80);
        drive_line(1'b0);
        fill_seq(8, 8'h90);
        drive_line(1'b0);
        frame_end();

        for (int i = 0; i < 300 && (q0.size() + q1.size() + q2.size()) > 0; i++) wait_clks(1);
        check_queues_empty("final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
